// File: rtl/bsg_sort_pkg.sv
// Shared helpers and stage control record for the odd-even transposition sorter.
// Latency: none (declarations only). Backpressure: not applicable.
// Optional swap counting is enabled with BSG_SORT_SWAP_COUNT_EN.
package bsg_sort_pkg;

    // Bit offset of element k inside a packed vector of width-bit elements.
    function automatic int elem_lsb(input int k, input int width);
        return k * width;
    endfunction

    // Worst-case swap total is els*(els-1)/2, which always fits in this width.
    function automatic int swap_count_width(input int els);
        return $clog2((els * els) / 2 + 1);
    endfunction

    // Width-independent part of a stage; the top wraps it with the vector and count,
    // whose widths depend on the instance parameters.
    typedef struct packed {
        logic v;
        logic descend;
        logic swapped;
    } stage_ctrl_t;

endpackage

// File: rtl/bsg_sort_cas_round.sv
// One odd-even transposition round: compare-and-swap on pairs (i, i+1) with i of the given parity.
// Latency: combinational. Backpressure: none; the enclosing stage register decides when to load.
// BSG_SORT_SWAP_COUNT_EN adds swap_count_o with the number of swaps done in this round.
module bsg_sort_cas_round
    import bsg_sort_pkg::*;
#(
    parameter int width_p = 16,
    parameter int els_p   = 4,
    parameter int parity  = 0
) (
    input  logic [els_p*width_p-1:0] data_i,
    input  logic                     descend_i,
    output logic [els_p*width_p-1:0] data_o,
`ifdef BSG_SORT_SWAP_COUNT_EN
    output logic [swap_count_width(els_p)-1:0] swap_count_o,
`endif
    output logic                     swapped_o
);

    always_comb begin
        logic [width_p-1:0] lo;
        logic [width_p-1:0] hi;
        lo        = '0;
        hi        = '0;
        data_o    = data_i;
        swapped_o = 1'b0;
`ifdef BSG_SORT_SWAP_COUNT_EN
        swap_count_o = '0;
`endif
        for (int i = parity; i + 1 < els_p; i += 2) begin
            lo = data_i[elem_lsb(i, width_p) +: width_p];
            hi = data_i[elem_lsb(i + 1, width_p) +: width_p];
            // Strict compares keep equal elements in place, so the sort is stable.
            if (descend_i ? (lo < hi) : (lo > hi)) begin
                data_o[elem_lsb(i, width_p) +: width_p]     = hi;
                data_o[elem_lsb(i + 1, width_p) +: width_p] = lo;
                swapped_o = 1'b1;
`ifdef BSG_SORT_SWAP_COUNT_EN
                swap_count_o = swap_count_o + swap_count_width(els_p)'(1);
`endif
            end
        end
    end

endmodule

// File: rtl/bsg_sort_odd_even_pipe.sv
// Pipelined odd-even transposition sorter, one register stage per round (swap_count_o with BSG_SORT_SWAP_COUNT_EN).
// Latency: els_p cycles from accept to v_o; throughput one vector per cycle.
// Backpressure: v_o/data_o hold until yumi_i; ready_o is a bubble-free combinational chain from yumi_i.
module bsg_sort_odd_even_pipe
    import bsg_sort_pkg::*;
#(
    parameter int width_p           = 16,
    parameter int els_p             = 4,
    parameter bit descend_default_p = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic [els_p*width_p-1:0] data_i,
    input  logic                     descend_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [els_p*width_p-1:0] data_o,
    output logic                     swapped_o,
`ifdef BSG_SORT_SWAP_COUNT_EN
    output logic [swap_count_width(els_p)-1:0] swap_count_o,
`endif
    input  logic                     yumi_i
);

    localparam int vec_w_lp = els_p * width_p;
    localparam int last_lp  = els_p - 1;
`ifdef BSG_SORT_SWAP_COUNT_EN
    localparam int cnt_w_lp = swap_count_width(els_p);
`endif

    typedef struct packed {
        stage_ctrl_t          ctrl;
        logic [vec_w_lp-1:0]  data;
`ifdef BSG_SORT_SWAP_COUNT_EN
        logic [cnt_w_lp-1:0]  count;
`endif
    } stage_t;

    stage_t              stage [els_p];
    stage_t              src   [els_p];
    stage_t              nxt   [els_p];
    logic [els_p-1:0]    load;
    logic [vec_w_lp-1:0] rnd_data [els_p];
    logic [els_p-1:0]    rnd_sw;
`ifdef BSG_SORT_SWAP_COUNT_EN
    logic [cnt_w_lp-1:0] rnd_cnt [els_p];
`endif

    // Round r operates on what stage r would load: the input for r=0, else stage r-1.
    always_comb begin
        src[0]              = '0;
        src[0].ctrl.v       = v_i;
        src[0].ctrl.descend = descend_i;
        src[0].data         = data_i;
        for (int r = 1; r < els_p; r++) begin
            src[r] = stage[r-1];
        end
    end

    for (genvar r = 0; r < els_p; r++) begin : g_round
        bsg_sort_cas_round #(
            .width_p (width_p),
            .els_p   (els_p),
            .parity  (r % 2)
        ) u_round (
            .data_i       (src[r].data),
            .descend_i    (src[r].ctrl.descend),
            .data_o       (rnd_data[r]),
`ifdef BSG_SORT_SWAP_COUNT_EN
            .swap_count_o (rnd_cnt[r]),
`endif
            .swapped_o    (rnd_sw[r])
        );
    end

    always_comb begin
        for (int r = 0; r < els_p; r++) begin
            nxt[r]              = src[r];
            nxt[r].data         = rnd_data[r];
            nxt[r].ctrl.swapped = src[r].ctrl.swapped | rnd_sw[r];
`ifdef BSG_SORT_SWAP_COUNT_EN
            nxt[r].count        = src[r].count + rnd_cnt[r];
`endif
        end
    end

    // A stage loads when empty or when the slot downstream of it frees up this cycle.
    always_comb begin
        logic free;
        load = '0;
        free = yumi_i;
        for (int r = last_lp; r >= 0; r--) begin
            load[r] = ~stage[r].ctrl.v | free;
            free    = load[r];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int r = 0; r < els_p; r++) begin
                stage[r]              <= '0;
                stage[r].ctrl.descend <= descend_default_p;
            end
        end else begin
            for (int r = 0; r < els_p; r++) begin
                if (load[r]) begin
                    stage[r] <= nxt[r];
                end
            end
        end
    end

    assign ready_o   = load[0];
    assign v_o       = stage[last_lp].ctrl.v;
    assign data_o    = stage[last_lp].data;
    assign swapped_o = stage[last_lp].ctrl.swapped;
`ifdef BSG_SORT_SWAP_COUNT_EN
    assign swap_count_o = stage[last_lp].count;
`endif

`ifndef SYNTHESIS
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
`endif

endmodule

// File: tb/tb_bsg_sort_odd_even_pipe.sv
// Self-checking bench for bsg_sort_odd_even_pipe (els_p=4 and els_p=3 instances, width 16).
// Reference model sorts with queue sort and counts inversions for the swap total.
module tb_bsg_sort_odd_even_pipe;
    import bsg_sort_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        v_i, descend_i, yumi_want, ready, v_o, swapped, yumi;
    logic [63:0] data_i, data_o;
    logic        v3, desc3, yw3, rdy3, vo3, sw3, yumi3;
    logic [47:0] data3_i, data3_o;
`ifdef BSG_SORT_SWAP_COUNT_EN
    logic [swap_count_width(4)-1:0] count4;
    logic [swap_count_width(3)-1:0] count3;
`endif

    assign yumi  = yumi_want & v_o;
    assign yumi3 = yw3 & vo3;

    bsg_sort_odd_even_pipe #(.width_p(16), .els_p(4), .descend_default_p(1'b0)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .v_i          (v_i),
        .data_i       (data_i),
        .descend_i    (descend_i),
        .ready_o      (ready),
        .v_o          (v_o),
        .data_o       (data_o),
        .swapped_o    (swapped),
`ifdef BSG_SORT_SWAP_COUNT_EN
        .swap_count_o (count4),
`endif
        .yumi_i       (yumi)
    );

    bsg_sort_odd_even_pipe #(.width_p(16), .els_p(3), .descend_default_p(1'b0)) dut3 (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .v_i          (v3),
        .data_i       (data3_i),
        .descend_i    (desc3),
        .ready_o      (rdy3),
        .v_o          (vo3),
        .data_o       (data3_o),
        .swapped_o    (sw3),
`ifdef BSG_SORT_SWAP_COUNT_EN
        .swap_count_o (count3),
`endif
        .yumi_i       (yumi3)
    );

    typedef struct {
        logic [63:0] data;
        logic        swapped;
        int          count;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_out, n_acc, first_out, last_out, first_acc;
    logic        last_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] v, input logic dsc, input int n);
        int unsigned q[$];
        exp_t r;
        int inv = 0;
        for (int k = 0; k < n; k++) q.push_back(int'(v[k*16 +: 16]));
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if (dsc ? (q[i] < q[j]) : (q[i] > q[j])) inv++;
        if (dsc) q.rsort(); else q.sort();
        r.data = '0;
        for (int k = 0; k < n; k++) r.data[k*16 +: 16] = 16'(q[k]);
        r.swapped = (inv != 0);
        r.count   = inv;
        return r;
    endfunction

    function automatic logic [63:0] rand_vec();
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            r[k*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7)) : 16'($urandom);
        return r;
    endfunction

    // One clock of stimulus on the 4-element DUT with scoreboard checking of consumed outputs.
    task automatic cycle(input logic vv, input logic [63:0] d, input logic dsc, input logic yw);
        exp_t e;
        @(negedge clk);
        v_i = vv; data_i = d; descend_i = dsc; yumi_want = yw;
        #1;
        last_ready = ready;
        if (v_o && yumi) begin
            if (sbq.size() == 0) begin
                check("spurious_out", 64'(v_o), 64'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_data", data_o, e.data);
                check("sb_swapped", 64'(swapped), 64'(e.swapped));
`ifdef BSG_SORT_SWAP_COUNT_EN
                check("sb_count", 64'(count4), 64'(e.count));
`endif
                if (n_out == 0) first_out = cyc;
                last_out = cyc;
                n_out++;
            end
        end
        if (vv && ready) begin
            if (n_acc == 0) first_acc = cyc;
            sbq.push_back(model(d, dsc, 4));
            n_acc++;
        end
        cyc++;
    endtask

    task automatic send_directed(input string tag, input logic [63:0] d, input logic dsc,
                                 input logic [63:0] exp_d, input logic exp_sw, input int exp_c);
        int lat;
        @(negedge clk);
        v_i = 1'b1; data_i = d; descend_i = dsc; yumi_want = 1'b0;
        @(negedge clk);
        v_i = 1'b0;
        lat = 1;
        while (!v_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_data"}, data_o, exp_d);
        check({tag, "_swapped"}, 64'(swapped), 64'(exp_sw));
`ifdef BSG_SORT_SWAP_COUNT_EN
        check({tag, "_count"}, 64'(count4), 64'(exp_c));
`endif
        yumi_want = 1'b1;
        @(negedge clk);
        yumi_want = 1'b0;
    endtask

    task automatic run3(input string tag, input logic [47:0] d, input logic dsc);
        exp_t e;
        int lat;
        e = model(64'(d), dsc, 3);
        @(negedge clk);
        v3 = 1'b1; data3_i = d; desc3 = dsc;
        @(negedge clk);
        v3 = 1'b0;
        lat = 1;
        while (!vo3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
        check({tag, "_data"}, 64'(data3_o), e.data);
        check({tag, "_swapped"}, 64'(sw3), 64'(e.swapped));
`ifdef BSG_SORT_SWAP_COUNT_EN
        check({tag, "_count"}, 64'(count3), 64'(e.count));
`endif
        yw3 = 1'b1;
        @(negedge clk);
        yw3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] held;
        int          vcount;
        reset_n = 1'b0;
        v_i = 1'b0; data_i = '0; descend_i = 1'b0; yumi_want = 1'b0;
        v3 = 1'b0; data3_i = '0; desc3 = 1'b0; yw3 = 1'b0;

        // Reset state
        #2;
        check("rst_v_o", 64'(v_o), 64'd0);
        check("rst_swapped", 64'(swapped), 64'd0);
        check("rst_data", data_o, 64'd0);
        check("rst_v3", 64'(vo3), 64'd0);
`ifdef BSG_SORT_SWAP_COUNT_EN
        check("rst_count", 64'(count4), 64'd0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_ready3", 64'(rdy3), 64'd1);

        // Directed vectors; element 0 is the lowest 16 bits
        send_directed("asc_3142", 64'h0002_0004_0001_0003, 1'b0, 64'h0004_0003_0002_0001, 1'b1, 3);
        send_directed("asc_sorted", 64'h0004_0003_0002_0001, 1'b0, 64'h0004_0003_0002_0001, 1'b0, 0);
        send_directed("desc_sorted", 64'h0004_0003_0002_0001, 1'b1, 64'h0001_0002_0003_0004, 1'b1, 6);
        send_directed("dups_7707", 64'h0007_0000_0007_0007, 1'b0, 64'h0007_0007_0007_0000, 1'b1, 2);
        send_directed("extremes", 64'h0001_8000_0000_FFFF, 1'b0, 64'hFFFF_8000_0001_0000, 1'b1, 4);

        // Odd element count
        run3("odd_591", 48'h0001_0009_0005, 1'b0);
        check("odd_591_literal", 64'(data3_o), 64'h0009_0005_0001);
        for (int i = 0; i < 6; i++) run3("odd_rand", rand_vec()[47:0], 1'($urandom_range(0, 1)));

        // Back-to-back at full throughput
        n_out = 0; n_acc = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, rand_vec(), 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("b2b_acc", 64'(n_acc), 64'd10);
        check("b2b_outs", 64'(n_out), 64'd10);
        check("b2b_first_latency", 64'(first_out - first_acc), 64'd4);
        check("b2b_consecutive", 64'(last_out - first_out), 64'd9);

        // Stall the consumer with input still offered
        n_out = 0; n_acc = 0; held = '0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, rand_vec(), 1'b0, 1'b0);
            if (i == 4) held = data_o;
            if (i == 5) begin
                check("hold_v_o", 64'(v_o), 64'd1);
                check("hold_data_stable", data_o, held);
            end
        end
        check("hold_acc", 64'(n_acc), 64'd4);
        check("hold_ready_low", 64'(last_ready), 64'd0);
        cycle(1'b1, rand_vec(), 1'b1, 1'b1);
        check("full_accept_and_yumi_ready", 64'(last_ready), 64'd1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("hold_outs", 64'(n_out), 64'd5);
        check("hold_sb_empty", 64'(sbq.size()), 64'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 3) != 0), rand_vec(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("rand_sb_empty", 64'(sbq.size()), 64'd0);

        // Reset with a full pipeline
        for (int i = 0; i < 5; i++) cycle(1'b1, rand_vec(), 1'b0, 1'b0);
        check("pre_reset_v_o", 64'(v_o), 64'd1);
        @(negedge clk);
        v_i = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_reset_v_o", 64'(v_o), 64'd0);
        check("mid_reset_data", data_o, 64'd0);
        sbq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            vcount += int'(v_o);
        end
        check("post_reset_no_out", 64'(vcount), 64'd0);
        n_out = 0;
        cycle(1'b1, rand_vec(), 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("post_reset_out", 64'(n_out), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
